// File: rtl/mc_core_seq.sv
// Multi-cycle instruction sequencer: owns PC/IR, handshakes with instruction and data
// memories, gates register-file writes and keeps cycle / retired-instruction counters.
module mc_core_seq #(
    parameter int PC_W     = 10,
    parameter int INST_W   = 32,
    parameter int XLEN     = 64,
    parameter int BR_SHIFT = 2,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              halt_i,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              is_mem,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   imm,
    output logic              dmem_en,
    input  logic              dmem_ack,
    output logic              rf_we_en,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] ir,
    output logic              ir_load,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    // state  | meaning
    // FETCH  | imem_req high, wait for imem_ack, capture ir
    // DECODE | ir stable, downstream decode settles
    // EXEC   | capture branch decision and target
    // MEM    | dmem_en high, wait for dmem_ack
    // WB     | rf write gate, advance pc, retire
    // HALT   | idle until halt_i drops; counters frozen
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   tgt_q;
    logic              taken_q;
    logic [INST_W-1:0] ir_q;
    logic              ir_load_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  instret_cnt_q;

    // Strobes come straight from the state register; rstn gating keeps them low during reset.
    assign imem_req    = rstn && (state_q == FETCH);
    assign dmem_en     = rstn && (state_q == MEM);
    assign rf_we_en    = rstn && (state_q == WB);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign ir_load     = ir_load_q;
    assign state       = state_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= FETCH;
            pc_q          <= PC_W'(RESET_PC);
            tgt_q         <= '0;
            taken_q       <= 1'b0;
            ir_q          <= '0;
            ir_load_q     <= 1'b0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            ir_load_q <= 1'b0;
            if (state_q != HALT) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        ir_q      <= imem_rdata;
                        ir_load_q <= 1'b1;
                        state_q   <= DECODE;
                    end
                end
                DECODE: state_q <= EXEC;
                EXEC: begin
                    taken_q <= branch_taken;
                    // Arithmetic shift turns the byte offset into a word offset, sign preserved.
                    tgt_q   <= pc_q + PC_W'($signed(imm) >>> BR_SHIFT);
                    state_q <= is_mem ? MEM : WB;
                end
                MEM: begin
                    if (dmem_ack) begin
                        state_q <= WB;
                    end
                end
                WB: begin
                    pc_q          <= taken_q ? tgt_q : pc_q + PC_W'(1);
                    instret_cnt_q <= instret_cnt_q + CNT_W'(1);
                    state_q       <= halt_i ? HALT : FETCH;
                end
                HALT: begin
                    if (!halt_i) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule
